// File: rtl/multdiv_pkg.sv
// Shared types and latency helper for the iterative signed multiply/divide unit.
// Build option MULTDIV_RADIX4_EN selects radix-4 Booth multiply (2 bits per cycle).
package multdiv_pkg;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;
  typedef enum logic {OP_MULT, OP_DIV} op_e;

  // Cycles from start edge to the result-ready cycle.
  function automatic int lat(input op_e op, input int width);
    int cycles;
    cycles = width + 1;
`ifdef MULTDIV_RADIX4_EN
    if (op == OP_MULT) cycles = width / 2 + 1;
`else
    if (op == OP_MULT) cycles = width + 1;
`endif
    return cycles;
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// Operand/control/result bundle between the pipeline and the multdiv unit.
interface multdiv_if #(parameter int WIDTH = 32);

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             data_busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_remainder, data_exception, data_resultRDY, data_busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_remainder, data_exception, data_resultRDY, data_busy
  );

endinterface

// File: rtl/multdiv_step.sv
// One combinational iteration: Booth add/sub + arithmetic shift, or non-restoring divide step.
// MULTDIV_RADIX4_EN switches the multiply step to radix-4 Booth.
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = WIDTH + 2
) (
  input  op_e              op_i,
  input  logic [AW-1:0]    acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             qm1_i,
  input  logic [AW-1:0]    m_i,
  output logic [AW-1:0]    acc_o,
  output logic [WIDTH-1:0] q_o,
  output logic             qm1_o
);

  logic [AW-1:0] sum;
  logic [AW-1:0] shl;

  always_comb begin
    sum   = acc_i;
    shl   = '0;
    acc_o = acc_i;
    q_o   = q_i;
    qm1_o = qm1_i;
    if (op_i == OP_DIV) begin
      // Subtract while the partial remainder is non-negative, add it back otherwise.
      shl   = {acc_i[AW-2:0], q_i[WIDTH-1]};
      sum   = acc_i[AW-1] ? shl + m_i : shl - m_i;
      acc_o = sum;
      q_o   = {q_i[WIDTH-2:0], ~sum[AW-1]};
    end else begin
`ifdef MULTDIV_RADIX4_EN
      case ({q_i[1:0], qm1_i})
        3'b001, 3'b010: sum = acc_i + m_i;
        3'b011:         sum = acc_i + (m_i << 1);
        3'b100:         sum = acc_i - (m_i << 1);
        3'b101, 3'b110: sum = acc_i - m_i;
        default:        sum = acc_i;
      endcase
      acc_o = {{2{sum[AW-1]}}, sum[AW-1:2]};
      q_o   = {sum[1:0], q_i[WIDTH-1:2]};
      qm1_o = q_i[1];
`else
      case ({q_i[0], qm1_i})
        2'b01:   sum = acc_i + m_i;
        2'b10:   sum = acc_i - m_i;
        default: sum = acc_i;
      endcase
      acc_o = {sum[AW-1], sum[AW-1:1]};
      q_o   = {sum[0], q_i[WIDTH-1:1]};
      qm1_o = q_i[0];
`endif
    end
  end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide: FSM, counter, accumulator/Q registers, sign fix-up, output hold.
// Build option MULTDIV_RADIX4_EN halves multiply latency via radix-4 Booth.
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clock,
  input  logic     reset_n,
  multdiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int AW    = WIDTH + 2;
  localparam logic [CNT_W-1:0] MULT_ITER = CNT_W'(lat(OP_MULT, WIDTH) - 1);
  localparam logic [CNT_W-1:0] DIV_ITER  = CNT_W'(lat(OP_DIV, WIDTH) - 1);
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      acc_q, acc_d, m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0]   res_q, res_d, rem_q, rem_d;
  logic               exc_q, exc_d;

  logic [AW-1:0]      step_acc;
  logic [WIDTH-1:0]   step_q;
  logic               step_qm1;
  logic [WIDTH-1:0]   a_mag, b_mag, rem_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_res, fix_rem;
  logic               fix_exc;

  multdiv_step #(.WIDTH(WIDTH), .AW(AW)) u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .acc_o (step_acc),
    .q_o   (step_q),
    .qm1_o (step_qm1)
  );

  assign a_mag = bus.data_operandA[WIDTH-1] ? '0 - bus.data_operandA : bus.data_operandA;
  assign b_mag = bus.data_operandB[WIDTH-1] ? '0 - bus.data_operandB : bus.data_operandB;

  // Final result from the iteration registers; only meaningful in DONE.
  always_comb begin
    prod    = {acc_q[WIDTH-1:0], q_q};
    rem_mag = acc_q[AW-1] ? WIDTH'(acc_q + m_q) : acc_q[WIDTH-1:0];
    fix_res = '0;
    fix_rem = '0;
    fix_exc = 1'b0;
    if (op_q == OP_MULT) begin
      fix_res = prod[WIDTH-1:0];
      fix_exc = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
    end else if (dz_q) begin
      fix_exc = 1'b1;
    end else begin
      fix_res = neg_quo_q ? '0 - q_q : q_q;
      fix_rem = neg_rem_q ? '0 - rem_mag : rem_mag;
      fix_exc = ovf_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    rem_d     = rem_q;
    exc_d     = exc_q;
    if (bus.ctrl_MULT || bus.ctrl_DIV) begin
      // A start pulse always wins, aborting whatever is in flight.
      acc_d = '0;
      qm1_d = 1'b0;
      res_d = '0;
      rem_d = '0;
      exc_d = 1'b0;
      if (bus.ctrl_MULT) begin
        state_d = MULT;
        op_d    = OP_MULT;
        cnt_d   = MULT_ITER;
        q_d     = bus.data_operandB;
        m_d     = {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
      end else begin
        state_d   = DIV;
        op_d      = OP_DIV;
        cnt_d     = DIV_ITER;
        q_d       = a_mag;
        m_d       = {2'b00, b_mag};
        neg_quo_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        neg_rem_d = bus.data_operandA[WIDTH-1];
        dz_d      = bus.data_operandB == '0;
        ovf_d     = (bus.data_operandA == MIN_VAL) && (bus.data_operandB == '1);
      end
    end else begin
      case (state_q)
        MULT, DIV: begin
          acc_d = step_acc;
          q_d   = step_q;
          qm1_d = step_qm1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
          res_d   = fix_res;
          rem_d   = fix_rem;
          exc_d   = fix_exc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      rem_q     <= '0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      rem_q     <= rem_d;
      exc_q     <= exc_d;
    end
  end

  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.data_busy      = (state_q != IDLE);
  assign bus.data_result    = (state_q == DONE) ? fix_res : res_q;
  assign bus.data_remainder = (state_q == DONE) ? fix_rem : rem_q;
  assign bus.data_exception = (state_q == DONE) ? fix_exc : exc_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter: arithmetic reference model plus per-cycle compare.
// Honours MULTDIV_RADIX4_EN for the expected multiply latency.
module tb_multdiv_iter;

  localparam int W = 32;
`ifdef MULTDIV_RADIX4_EN
  localparam int LAT_MUL = W / 2 + 1;
`else
  localparam int LAT_MUL = W + 1;
`endif
  localparam int LAT_DIV = W + 1;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         exc;
  } res_t;

  typedef struct packed {
    logic         mul;
    logic         div;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [W-1:0] m;
    logic         e;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  multdiv_if #(.WIDTH(W)) bus ();

  multdiv_iter #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic res_t model(input logic mul, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t   r;
    longint sa, sb, p, q, m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    if (mul) begin
      p     = sa * sb;
      r.res = p[W-1:0];
      r.exc = (p != longint'($signed(r.res)));
    end else if (sb == 0) begin
      r.exc = 1'b1;
    end else if (sa == -(longint'(1) << (W-1)) && sb == -1) begin
      r.res = a;
      r.exc = 1'b1;
    end else begin
      q     = sa / sb;
      m     = sa % sb;
      r.res = q[W-1:0];
      r.rem = m[W-1:0];
    end
    return r;
  endfunction

  // Model timeline: 'left' = cycles remaining until and including the ready cycle.
  int   left = 0;
  res_t pend = '0;
  res_t expo = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      left <= 0;
      expo <= '0;
      pend <= '0;
    end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
      pend <= model(bus.ctrl_MULT, bus.data_operandA, bus.data_operandB);
      left <= bus.ctrl_MULT ? LAT_MUL : LAT_DIV;
      expo <= '0;
    end else if (left > 0) begin
      left <= left - 1;
      if (left == 2) expo <= pend;
    end
  end

  always @(negedge clock) begin
    check("cyc_busy", 64'(bus.data_busy), 64'(left > 0));
    check("cyc_rdy", 64'(bus.data_resultRDY), 64'(left == 1));
    check("cyc_result", 64'(bus.data_result), 64'(expo.res));
    check("cyc_remainder", 64'(bus.data_remainder), 64'(expo.rem));
    check("cyc_exception", 64'(bus.data_exception), 64'(expo.exc));
  end

  vec_t vecs [0:16] = '{
    '{1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFD6, 32'h0, 1'b0},
    '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 32'h0, 1'b1},
    '{1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h80000000, 32'h0, 1'b0},
    '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b0},
    '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h0, 1'b1},
    '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 32'h0, 1'b1},
    '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b1},
    '{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0},
    '{1'b0, 1'b1, 32'h00000064, 32'h00000000, 32'h00000000, 32'h0, 1'b1},
    '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b1},
    '{1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0},
    '{1'b0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0},
    '{1'b0, 1'b1, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0},
    '{1'b0, 1'b1, 32'h80000000, 32'h00000001, 32'h80000000, 32'h0, 1'b0},
    '{1'b0, 1'b1, 32'hFFFFFFFB, 32'h0000000A, 32'h00000000, 32'hFFFFFFFB, 1'b0},
    '{1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h7FFFFFFF, 1'b0},
    '{1'b1, 1'b1, 32'h00000006, 32'h00000003, 32'h00000012, 32'h0, 1'b0}
  };

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    @(negedge clock);
    bus.data_operandA = v.a;
    bus.data_operandB = v.b;
    bus.ctrl_MULT     = v.mul;
    bus.ctrl_DIV      = v.div;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    cyc = 1;
    while (bus.data_resultRDY !== 1'b1 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(v.mul ? LAT_MUL : LAT_DIV));
    check({tag, "_result"}, 64'(bus.data_result), 64'(v.r));
    check({tag, "_remainder"}, 64'(bus.data_remainder), 64'(v.m));
    check({tag, "_exception"}, 64'(bus.data_exception), 64'(v.e));
    $display("txn %s: op=%s a=0x%h b=0x%h -> result=0x%h rem=0x%h exc=%0b after %0d cycles",
             tag, v.mul ? "MULT" : "DIV", v.a, v.b, bus.data_result, bus.data_remainder,
             bus.data_exception, cyc);
  endtask

  initial begin
    int cyc;
    int rdy_cnt;
    reset_n           = 1'b1;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    check("reset_busy", 64'(bus.data_busy), 64'(0));
    check("reset_rdy", 64'(bus.data_resultRDY), 64'(0));
    check("reset_result", 64'(bus.data_result), 64'(0));
    check("reset_exception", 64'(bus.data_exception), 64'(0));

    for (int i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Restart: divide in flight, multiply issued in cycle 10 replaces it.
    @(negedge clock);
    bus.data_operandA = 32'd100;
    bus.data_operandB = 32'd7;
    bus.ctrl_DIV      = 1'b1;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    cyc     = 1;
    rdy_cnt = 0;
    while (cyc < 10) begin
      @(negedge clock);
      cyc++;
      if (bus.data_resultRDY === 1'b1) rdy_cnt++;
    end
    bus.data_operandA = 32'd3;
    bus.data_operandB = 32'd4;
    bus.ctrl_MULT     = 1'b1;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    cyc++;
    while (bus.data_resultRDY !== 1'b1 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check("restart_latency", 64'(cyc), 64'(10 + LAT_MUL));
    check("restart_early_rdy", 64'(rdy_cnt), 64'(0));
    check("restart_result", 64'(bus.data_result), 64'(12));
    $display("txn restart: DIV 100/7 aborted, MULT 3x4 -> result=0x%h at cycle %0d", bus.data_result, cyc);

    // Asynchronous reset in cycle 5 of a multiply.
    @(negedge clock);
    bus.data_operandA = 32'd5;
    bus.data_operandB = 32'd5;
    bus.ctrl_MULT     = 1'b1;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_busy", 64'(bus.data_busy), 64'(0));
    check("midreset_rdy", 64'(bus.data_resultRDY), 64'(0));
    check("midreset_result", 64'(bus.data_result), 64'(0));
    @(negedge clock);
    #2 reset_n = 1'b1;
    rdy_cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) rdy_cnt++;
    end
    check("midreset_no_rdy", 64'(rdy_cnt), 64'(0));
    $display("txn midreset: MULT 5x5 reset in cycle 5, ready pulses afterwards=%0d", rdy_cnt);

    run_vec('{1'b1, 1'b0, 32'd3, 32'hFFFFFFFC, 32'hFFFFFFF4, 32'h0, 1'b0}, "post_reset");

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
